// File: rtl/float_div_cynw_cm_float_qmul_e8_m23_pipe_if.sv
// ---------------------------------------------------------------------------
// float_div_cynw_cm_float_qmul_e8_m23_pipe_if
//
// Data bundle between the reciprocal stage and the quotient-multiply stage of
// the E8M23 float divider. It has no handshake: valid bits only.
//
//   in_vld   dividend valid, same cycle as the divisor at the reciprocal unit
//   b_sign   dividend sign
//   b_exp    dividend biased exponent
//   b_man    dividend fraction
//   x        reciprocal word: [36] sign, [35:28] biased exp, [27:0] 1.27 sig
//   out_vld  quotient valid
//   z        quotient {sign, exp[7:0], man[22:0]}
//   z_flags  {invalid, divzero, overflow, underflow}
//
// master: the producer of b/x and consumer of z.  slave: the multiply stage.
// ---------------------------------------------------------------------------
interface float_div_cynw_cm_float_qmul_e8_m23_pipe_if;
    logic        in_vld;
    logic        b_sign;
    logic [7:0]  b_exp;
    logic [22:0] b_man;
    logic [36:0] x;
    logic        out_vld;
    logic [31:0] z;
    logic [3:0]  z_flags;

    modport master (
        output in_vld, b_sign, b_exp, b_man, x,
        input  out_vld, z, z_flags
    );

    modport slave (
        input  in_vld, b_sign, b_exp, b_man, x,
        output out_vld, z, z_flags
    );
endinterface

// File: rtl/float_div_cynw_cm_float_qmul_e8_m23_pipe.sv
// ---------------------------------------------------------------------------
// float_div_cynw_cm_float_qmul_e8_m23_pipe
//
// Final stage of the E8M23 divider: z = b * rcp(a), where x = rcp(a) comes
// from the reciprocal unit RCP_LAT cycles after b is presented. b is held in
// a matching delay line so that it meets x. Rounding is RNE; subnormal inputs
// read as zero and subnormal results flush to zero.
//
// Ports
//   aclk    clock, rising edge
//   arstn   asynchronous active-low reset
//   astall  1 = freeze every register (delay line, pipe, outputs)
//   bus     slave side of the b/x -> z bundle (see the interface file)
//
// Pipeline (non-stalled cycles): D (RCP_LAT deep) -> M1 -> M2/out.
// in_vld at cycle t gives out_vld at t + RCP_LAT + 2.
// ---------------------------------------------------------------------------
module float_div_cynw_cm_float_qmul_e8_m23_pipe #(
    parameter int RCP_LAT = 1   // legal 1..4
) (
    input  logic aclk,
    input  logic arstn,
    input  logic astall,
    float_div_cynw_cm_float_qmul_e8_m23_pipe_if.slave bus
);

    // Operand class, resolved in M1 so M2 only has to pick the result.
    typedef enum logic [2:0] {
        CLS_NORMAL,   // finite nonzero b and x: use the rounded product
        CLS_NAN,      // default quiet NaN, invalid
        CLS_INF_DZ,   // signed infinity, divzero
        CLS_INF,      // signed infinity, no flag
        CLS_ZERO      // signed zero, no flag
    } cls_e;

    // -----------------------------------------------------------------------
    // D stage: delay line for {in_vld, b}
    // -----------------------------------------------------------------------
    logic [RCP_LAT-1:0]       dl_vld_d, dl_vld_q;
    logic [RCP_LAT-1:0][31:0] dl_b_d, dl_b_q;
    logic                     d_vld;
    logic [31:0]              d_b;

    always_comb begin
        dl_vld_d[0] = bus.in_vld;
        dl_b_d[0]   = {bus.b_sign, bus.b_exp, bus.b_man};
        for (int i = 1; i < RCP_LAT; i++) begin
            dl_vld_d[i] = dl_vld_q[i-1];
            dl_b_d[i]   = dl_b_q[i-1];
        end
    end

    assign d_vld = dl_vld_q[RCP_LAT-1];
    assign d_b   = dl_b_q[RCP_LAT-1];

    // -----------------------------------------------------------------------
    // M1 stage: sign, raw product, unbiased-sum exponent, special class
    // -----------------------------------------------------------------------
    logic              m1_vld_d, m1_vld_q;
    logic              m1_sign_d, m1_sign_q;
    logic [51:0]       m1_prod_d, m1_prod_q;
    logic signed [9:0] m1_exp_d, m1_exp_q;
    cls_e              m1_cls_d, m1_cls_q;

    logic b_zero, b_inf, b_nan;
    logic x_zero, x_inf, x_nan;

    // NOTE: every always_comb output gets a value before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        b_zero = (d_b[30:23] == 8'h00);
        b_inf  = (d_b[30:23] == 8'hFF) && (d_b[22:0] == 23'd0);
        b_nan  = (d_b[30:23] == 8'hFF) && (d_b[22:0] != 23'd0);
        x_zero = (bus.x[35:28] == 8'h00);
        x_inf  = (bus.x[35:28] == 8'hFF) && (bus.x[27:0] == 28'd0);
        x_nan  = (bus.x[35:28] == 8'hFF) && (bus.x[27:0] != 28'd0);

        m1_vld_d  = d_vld;
        m1_sign_d = d_b[31] ^ bus.x[36];
        // 1.23 times 1.27 gives a 2.50 product in [1,4).
        m1_prod_d = 52'({1'b1, d_b[22:0]}) * 52'(bus.x[27:0]);
        m1_exp_d  = $signed({2'b00, d_b[30:23]}) + $signed({2'b00, bus.x[35:28]}) - 10'sd127;

        // First match wins; the 0*inf and inf*0 forms fall out before the
        // divide-by-zero check, so that branch only sees finite nonzero b.
        m1_cls_d = CLS_NORMAL;
        if (b_nan || x_nan) begin
            m1_cls_d = CLS_NAN;
        end else if ((b_zero && x_inf) || (b_inf && x_zero)) begin
            m1_cls_d = CLS_NAN;
        end else if (x_inf && !b_inf) begin
            m1_cls_d = CLS_INF_DZ;
        end else if (b_inf || x_inf) begin
            m1_cls_d = CLS_INF;
        end else if (b_zero || x_zero) begin
            m1_cls_d = CLS_ZERO;
        end
    end

    // -----------------------------------------------------------------------
    // M2 stage: normalise, RNE round, range check, result select
    // -----------------------------------------------------------------------
    logic              out_vld_d, out_vld_q;
    logic [31:0]       z_d, z_q;
    logic [3:0]        z_flags_d, z_flags_q;

    logic [50:0]       norm;       // bits below the hidden one after normalising
    logic signed [9:0] e_norm;
    logic signed [9:0] e_rnd;
    logic              guard, rnd, sticky, round_up;
    logic [23:0]       frac_sum;   // [23] is the rounding carry-out

    always_comb begin
        norm   = m1_prod_q[51] ? m1_prod_q[50:0] : {m1_prod_q[49:0], 1'b0};
        e_norm = m1_prod_q[51] ? m1_exp_q + 10'sd1 : m1_exp_q;

        guard    = norm[27];
        rnd      = norm[26];
        sticky   = |norm[25:0];
        // Round up above half, or on an exact half when the kept LSB is odd.
        round_up = guard & (rnd | sticky | norm[28]);

        frac_sum = {1'b0, norm[50:28]} + {23'd0, round_up};
        // An all-ones fraction rolling over yields 2.0: fraction is already
        // zero, only the exponent moves.
        e_rnd    = frac_sum[23] ? e_norm + 10'sd1 : e_norm;

        out_vld_d = m1_vld_q;
        z_d       = z_q;
        z_flags_d = z_flags_q;
        if (m1_vld_q) begin
            z_flags_d = 4'b0000;
            case (m1_cls_q)
                CLS_NAN: begin
                    z_d       = 32'h7FC0_0000;
                    z_flags_d = 4'b1000;
                end
                CLS_INF_DZ: begin
                    z_d       = {m1_sign_q, 8'hFF, 23'd0};
                    z_flags_d = 4'b0100;
                end
                CLS_INF:  z_d = {m1_sign_q, 8'hFF, 23'd0};
                CLS_ZERO: z_d = {m1_sign_q, 31'd0};
                default: begin
                    if (e_rnd >= 10'sd255) begin
                        z_d       = {m1_sign_q, 8'hFF, 23'd0};
                        z_flags_d = 4'b0010;
                    end else if (e_rnd <= 10'sd0) begin
                        z_d       = {m1_sign_q, 31'd0};
                        z_flags_d = 4'b0001;
                    end else begin
                        z_d = {m1_sign_q, e_rnd[7:0], frac_sum[22:0]};
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: non-blocking assignments keep every stage sampling the values of
    // the previous cycle, independent of statement order.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            // NOTE: the delay-line payload is cleared along with its valid
            // bits so an aborted item leaves no trace after reset.
            dl_vld_q  <= '0;
            dl_b_q    <= '0;
            m1_vld_q  <= 1'b0;
            m1_sign_q <= 1'b0;
            m1_prod_q <= '0;
            m1_exp_q  <= '0;
            m1_cls_q  <= CLS_NORMAL;
            out_vld_q <= 1'b0;
            z_q       <= '0;
            z_flags_q <= '0;
        end else if (!astall) begin
            dl_vld_q  <= dl_vld_d;
            dl_b_q    <= dl_b_d;
            m1_vld_q  <= m1_vld_d;
            m1_sign_q <= m1_sign_d;
            m1_prod_q <= m1_prod_d;
            m1_exp_q  <= m1_exp_d;
            m1_cls_q  <= m1_cls_d;
            out_vld_q <= out_vld_d;
            z_q       <= z_d;
            z_flags_q <= z_flags_d;
        end
    end

    assign bus.out_vld = out_vld_q;
    assign bus.z       = z_q;
    assign bus.z_flags = z_flags_q;

endmodule

// File: tb/tb_float_div_cynw_cm_float_qmul_e8_m23_pipe.sv
// ---------------------------------------------------------------------------
// tb_float_div_cynw_cm_float_qmul_e8_m23_pipe
//
// Four instances (RCP_LAT = 1..4) share one item stream. Each instance gets
// its x delayed by its own latency. A reference model computes each quotient
// from the real product using exact integer arithmetic, and the bench predicts
// out_vld/z/z_flags on every cycle, including stalls and resets.
// ---------------------------------------------------------------------------
module tb_float_div_cynw_cm_float_qmul_e8_m23_pipe;

    localparam int NLAT  = 4;
    localparam int NITEM = 1024;

    typedef struct {
        logic        vld;
        logic [31:0] b;
        logic [36:0] x;
        logic        has_exp;   // directed item with a hand-computed result
        logic [35:0] exp;       // {flags, z}
    } item_t;

    typedef struct {
        int          due;       // advancing-edge count at which it shows up
        logic [35:0] res;
    } pend_t;

    logic                     aclk  = 1'b0;
    logic                     arstn = 1'b1;
    logic                     astall = 1'b0;
    logic                     in_vld = 1'b0;
    logic [31:0]              b_w = '0;
    logic [NLAT-1:0][36:0]    x_a = '0;
    wire  [NLAT-1:0]          out_vld_a;
    wire  [NLAT-1:0][31:0]    z_a;
    wire  [NLAT-1:0][3:0]     f_a;

    item_t       items [NITEM];
    int          stall_at [NITEM];
    bit          rst_at [NITEM];
    int          n_items = 0;
    int          cur_k = -1;
    int          adv_cnt = 0;
    pend_t       pq [NLAT][$];
    logic        e_vld [NLAT];
    logic [35:0] e_res [NLAT];
    bit          checking = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 aclk = ~aclk;

    for (genvar g = 0; g < NLAT; g++) begin : g_dut
        float_div_cynw_cm_float_qmul_e8_m23_pipe_if bus ();

        assign bus.in_vld   = in_vld;
        assign bus.b_sign   = b_w[31];
        assign bus.b_exp    = b_w[30:23];
        assign bus.b_man    = b_w[22:0];
        assign bus.x        = x_a[g];
        assign out_vld_a[g] = bus.out_vld;
        assign z_a[g]       = bus.z;
        assign f_a[g]       = bus.z_flags;

        float_div_cynw_cm_float_qmul_e8_m23_pipe #(.RCP_LAT(g + 1)) u_dut (
            .aclk   (aclk),
            .arstn  (arstn),
            .astall (astall),
            .bus    (bus)
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference: IEEE special cases by rule, otherwise the exact integer
    // product rounded to 24 significant bits, ties to even.
    function automatic logic [35:0] ref_qmul(input logic [31:0] b, input logic [36:0] x);
        logic            s, b_zero, b_inf, b_nan, x_zero, x_inf, x_nan;
        int              be, xe, msb, sh, e;
        longint unsigned p, q, rem, half;
        s      = b[31] ^ x[36];
        be     = int'(b[30:23]);
        xe     = int'(x[35:28]);
        b_zero = (be == 0);
        b_inf  = (be == 255) && (b[22:0] == 0);
        b_nan  = (be == 255) && (b[22:0] != 0);
        x_zero = (xe == 0);
        x_inf  = (xe == 255) && (x[27:0] == 0);
        x_nan  = (xe == 255) && (x[27:0] != 0);
        if (b_nan || x_nan) return {4'b1000, 32'h7FC0_0000};
        if ((b_zero && x_inf) || (b_inf && x_zero)) return {4'b1000, 32'h7FC0_0000};
        if (x_inf && !b_zero && !b_inf) return {4'b0100, s, 8'hFF, 23'd0};
        if (b_inf || x_inf) return {4'b0000, s, 8'hFF, 23'd0};
        if (b_zero || x_zero) return {4'b0000, s, 31'd0};
        p   = 64'({1'b1, b[22:0]}) * 64'(x[27:0]);
        msb = 63;
        while (msb > 0 && !p[msb]) msb--;
        sh   = msb - 23;
        q    = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            msb++;
        end
        // A product with its top bit at weight 2^50 is the value 1.x.
        e = be + xe - 127 + (msb - 50);
        if (e >= 255) return {4'b0010, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0001, s, 31'd0};
        return {4'b0000, s, 8'(e), q[22:0]};
    endfunction

    function automatic item_t rand_item(input logic force_vld);
        item_t       it;
        logic [7:0]  be, xe;
        logic [22:0] bm;
        logic [27:0] xs;
        bm = 23'($urandom);
        xs = {1'b1, 27'($urandom)};
        case ($urandom_range(0, 15))
            0:       be = 8'h00;
            1:       begin be = 8'hFF; bm = '0; end
            2:       be = 8'hFF;
            3, 4, 5: be = 8'($urandom_range(1, 254));
            default: be = 8'($urandom_range(100, 154));
        endcase
        case ($urandom_range(0, 15))
            0:       xe = 8'h00;
            1:       begin xe = 8'hFF; xs = '0; end
            2:       xe = 8'hFF;
            3, 4, 5: xe = 8'($urandom_range(1, 254));
            default: xe = 8'($urandom_range(100, 154));
        endcase
        it.vld     = force_vld || ($urandom_range(0, 3) != 0);
        it.b       = {1'($urandom), be, bm};
        it.x       = {1'($urandom), xe, xs};
        it.has_exp = 1'b0;
        it.exp     = '0;
        return it;
    endfunction

    task automatic add_item(input item_t it);
        items[n_items]    = it;
        stall_at[n_items] = 0;
        rst_at[n_items]   = 1'b0;
        n_items++;
    endtask

    task automatic add_dir(input logic [31:0] b, input logic [36:0] x, input logic [35:0] exp);
        item_t it;
        it.vld = 1'b1; it.b = b; it.x = x; it.has_exp = 1'b1; it.exp = exp;
        add_item(it);
    endtask

    // Present item k (or hold everything when stalled) and run one cycle.
    task automatic step(input int k, input logic stall);
        astall = stall;
        if (!stall) begin
            cur_k  = k;
            in_vld = items[k].vld;
            b_w    = items[k].b;
            for (int d = 0; d < NLAT; d++)
                x_a[d] = (k - d - 1 >= 0) ? items[k - d - 1].x : '0;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        arstn = 1'b0;
        for (int d = 0; d < NLAT; d++) begin
            pq[d].delete();
            e_vld[d] = 1'b0;
            e_res[d] = '0;
        end
        #1;
        for (int d = 0; d < NLAT; d++)
            check($sformatf("lat%0d_rst_now", d + 1),
                  {27'd0, out_vld_a[d], f_a[d], z_a[d]}, 64'd0);
        repeat (cycles) @(posedge aclk);
        #1;
        arstn = 1'b1;
    endtask

    // Prediction: on each advancing edge, retire what is due and enqueue the
    // item just captured, RCP_LAT + 1 further advancing edges away.
    always @(posedge aclk) begin
        if (arstn && !astall) begin
            adv_cnt++;
            for (int d = 0; d < NLAT; d++) begin
                if (pq[d].size() > 0 && pq[d][0].due == adv_cnt) begin
                    e_vld[d] = 1'b1;
                    e_res[d] = pq[d][0].res;
                    void'(pq[d].pop_front());
                end else begin
                    e_vld[d] = 1'b0;
                end
                if (cur_k >= 0 && items[cur_k].vld) begin
                    pend_t p;
                    p.due = adv_cnt + d + 2;
                    p.res = items[cur_k].has_exp ? items[cur_k].exp
                                                 : ref_qmul(items[cur_k].b, items[cur_k].x);
                    pq[d].push_back(p);
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (checking) begin
            for (int d = 0; d < NLAT; d++)
                check($sformatf("lat%0d_out", d + 1),
                      {27'd0, out_vld_a[d], f_a[d], z_a[d]},
                      {27'd0, e_vld[d], e_res[d]});
        end
    end

    initial begin
        item_t idle;
        int    mark;

        for (int d = 0; d < NLAT; d++) begin
            e_vld[d] = 1'b0;
            e_res[d] = '0;
        end

        // Directed: nominal, range limits, special cases, rounding corners.
        add_dir(32'h40C0_0000, {1'b0, 8'd126, 28'h800_0000}, {4'h0, 32'h4040_0000});
        add_dir(32'hC0C0_0000, {1'b0, 8'd126, 28'h800_0000}, {4'h0, 32'hC040_0000});
        add_dir(32'h7F00_0000, {1'b0, 8'd129, 28'h800_0000}, {4'h2, 32'h7F80_0000});
        add_dir(32'h0080_0000, {1'b0, 8'd100, 28'h800_0000}, {4'h1, 32'h0000_0000});
        add_dir(32'h3F80_0000, {1'b0, 8'hFF,  28'h000_0000}, {4'h4, 32'h7F80_0000});
        add_dir(32'h0000_0000, {1'b0, 8'hFF,  28'h000_0000}, {4'h8, 32'h7FC0_0000});
        add_dir(32'hFFC0_0001, {1'b0, 8'd127, 28'h800_0000}, {4'h8, 32'h7FC0_0000});
        add_dir(32'h3F80_0001, {1'b0, 8'd127, 28'hC00_0000}, {4'h0, 32'h3FC0_0002});
        add_dir(32'h3F80_0003, {1'b0, 8'd127, 28'hC00_0000}, {4'h0, 32'h3FC0_0004});
        add_dir(32'h3FFF_FFFE, {1'b0, 8'd127, 28'h800_000D}, {4'h0, 32'h4000_0000});

        // Eight back-to-back items with a three-cycle stall in the middle.
        mark = n_items;
        for (int i = 0; i < 8; i++) add_item(rand_item(1'b1));
        stall_at[mark + 4] = 3;

        idle = rand_item(1'b0);
        idle.vld = 1'b0;
        for (int i = 0; i < 6; i++) add_item(idle);

        // Three items in flight, then reset; the next item must come out clean.
        for (int i = 0; i < 3; i++) add_item(rand_item(1'b1));
        rst_at[n_items] = 1'b1;
        add_dir(32'h40C0_0000, {1'b0, 8'd126, 28'h800_0000}, {4'h0, 32'h4040_0000});

        // Random regression with sporadic stalls.
        for (int i = 0; i < 500; i++) begin
            add_item(rand_item(1'b0));
            if ($urandom_range(0, 9) == 0) stall_at[n_items - 1] = $urandom_range(1, 3);
        end
        for (int i = 0; i < 10; i++) add_item(idle);

        @(posedge aclk);
        #1;
        apply_reset(2);
        checking = 1'b1;

        for (int k = 0; k < n_items; k++) begin
            if (rst_at[k]) apply_reset(2);
            for (int s = 0; s < stall_at[k]; s++) step(k, 1'b1);
            step(k, 1'b0);
        end

        for (int d = 0; d < NLAT; d++)
            check($sformatf("lat%0d_drain", d + 1), 64'(pq[d].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
